// File: rtl/io_chan_router.sv
// io_chan_router: per-channel input FIFOs draining the selected channel into the
// I/O section, plus one timed-strobe output engine with ack wait and timeout.
module io_chan_router #(
  parameter int NCHAN = 4,
  parameter int DATA_W = 5,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] STOP_CODE = DATA_W'(5'b00010),
  parameter int PULSE_CYC = 8,
  parameter int ACK_TIMEOUT = 1024,
  parameter int GAP_CYC = 4
) (
  input  logic                      CLOCK,
  input  logic                      rst_n,
  input  logic [$clog2(NCHAN)-1:0]  sel,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [NCHAN*DATA_W-1:0]   dev_in_data,
  input  logic [NCHAN-1:0]          dev_in_stb,
  output logic [NCHAN-1:0]          dev_in_full,
  output logic                      io_in_valid,
  output logic [DATA_W-1:0]         io_in_data,
  output logic                      io_in_stop,
  input  logic                      io_in_req,
  input  logic                      io_out_stb,
  input  logic [DATA_W-1:0]         io_out_data,
  output logic                      io_out_busy,
  output logic [DATA_W-1:0]         dev_out_data,
  output logic [NCHAN-1:0]          dev_out_pulse,
  input  logic [NCHAN-1:0]          dev_out_ack,
  output logic [NCHAN-1:0]          err_overflow,
  output logic                      err_timeout
);

  localparam int SEL_W = $clog2(NCHAN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_MAX = (ACK_TIMEOUT > PULSE_CYC) ?
                           ((ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC) :
                           ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  logic [DATA_W-1:0] mem [NCHAN][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NCHAN];
  logic [PTR_W-1:0]  wr_ptr [NCHAN];
  logic [CNT_W-1:0]  cnt [NCHAN];
  logic [NCHAN-1:0]  full, push_ok, pop_ok, flush_ch;
  logic [DATA_W-1:0] head;

  // A push to a full FIFO is dropped even if the same cycle pops it.
  always_comb begin
    full     = '0;
    push_ok  = '0;
    pop_ok   = '0;
    flush_ch = '0;
    for (int k = 0; k < NCHAN; k++) begin
      full[k]     = (cnt[k] == CNT_W'(FIFO_DEPTH));
      flush_ch[k] = flush && (sel == SEL_W'(k));
      push_ok[k]  = dev_in_stb[k] && !full[k] && !flush_ch[k];
      pop_ok[k]   = (sel == SEL_W'(k)) && io_in_valid && io_in_req;
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCHAN; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      err_overflow <= '0;
    end else begin
      for (int k = 0; k < NCHAN; k++) begin
        if (dev_in_stb[k] && full[k]) err_overflow[k] <= 1'b1;
        if (flush_ch[k]) begin
          rd_ptr[k] <= '0;
          wr_ptr[k] <= '0;
          cnt[k]    <= '0;
        end else begin
          if (push_ok[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
          if (pop_ok[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
          cnt[k] <= cnt[k] + CNT_W'(push_ok[k]) - CNT_W'(pop_ok[k]);
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    for (int k = 0; k < NCHAN; k++) begin
      if (push_ok[k]) mem[k][wr_ptr[k]] <= dev_in_data[k*DATA_W +: DATA_W];
    end
  end

  assign head        = mem[sel][rd_ptr[sel]];
  assign io_in_valid = enable && (cnt[sel] != '0);
  assign io_in_data  = head;
  assign io_in_stop  = io_in_valid && (head == STOP_CODE);
  assign dev_in_full = full;

  // state      | meaning
  // S_IDLE     | waiting for io_out_stb & enable
  // S_PULSE    | strobe on latched channel, PULSE_CYC cycles
  // S_WAIT_ACK | waiting for ack on latched channel, ACK_TIMEOUT cycles max
  // S_GAP      | device recovery, GAP_CYC cycles
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_ACK, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [SEL_W-1:0]  chan_q;
  logic [DATA_W-1:0] data_q;
  logic              latch, tmo_hit;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tmr         <= '0;
      chan_q      <= '0;
      data_q      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if (latch) begin
        chan_q <= sel;
        data_q <= io_out_data;
      end
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end

  // Timer counts down; each phase ends on the cycle it reads zero.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    latch     = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (io_out_stb && enable) begin
          latch     = 1'b1;
          state_nxt = S_PULSE;
          tmr_nxt   = TMR_W'(PULSE_CYC - 1);
        end
      end
      S_PULSE: begin
        if (tmr == '0) begin
          state_nxt = S_WAIT_ACK;
          tmr_nxt   = TMR_W'(ACK_TIMEOUT - 1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (dev_out_ack[chan_q]) begin
          state_nxt = S_GAP;
          tmr_nxt   = TMR_W'(GAP_CYC - 1);
        end else if (tmr == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = S_GAP;
          tmr_nxt   = TMR_W'(GAP_CYC - 1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_GAP: begin
        if (tmr == '0) state_nxt = S_IDLE;
        else           tmr_nxt   = tmr - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dev_out_pulse = '0;
    if (state == S_PULSE) dev_out_pulse[chan_q] = 1'b1;
  end

  assign io_out_busy  = (state != S_IDLE);
  assign dev_out_data = data_q;

endmodule

// File: tb/tb_io_chan_router.sv
// Scoreboard bench for io_chan_router: a queue-level reference model predicts
// deliveries, flags and strobes; an independent monitor compares the DUT.
module tb_io_chan_router;
  localparam int NCHAN = 4;
  localparam int DATA_W = 5;
  localparam int DEPTH = 4;
  localparam int PULSE_CYC = 8;
  localparam int ACK_TIMEOUT = 1024;
  localparam int GAP_CYC = 4;
  localparam logic [4:0] STOP_CODE = 5'b00010;

  logic CLOCK = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] sel = '0;
  logic enable = 1'b0, flush = 1'b0;
  logic [NCHAN*DATA_W-1:0] dev_in_data = '0;
  logic [NCHAN-1:0] dev_in_stb = '0;
  logic [NCHAN-1:0] dev_in_full;
  logic io_in_valid, io_in_stop, io_out_busy, err_timeout;
  logic [4:0] io_in_data, dev_out_data;
  logic io_in_req = 1'b0, io_out_stb = 1'b0;
  logic [4:0] io_out_data = '0;
  logic [NCHAN-1:0] dev_out_pulse, err_overflow;
  logic [NCHAN-1:0] dev_out_ack = '0;

  always #5 CLOCK = ~CLOCK;

  io_chan_router #(
    .NCHAN(NCHAN), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .STOP_CODE(STOP_CODE),
    .PULSE_CYC(PULSE_CYC), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYC(GAP_CYC)
  ) dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .sel(sel), .enable(enable), .flush(flush),
    .dev_in_data(dev_in_data), .dev_in_stb(dev_in_stb), .dev_in_full(dev_in_full),
    .io_in_valid(io_in_valid), .io_in_data(io_in_data), .io_in_stop(io_in_stop),
    .io_in_req(io_in_req), .io_out_stb(io_out_stb), .io_out_data(io_out_data),
    .io_out_busy(io_out_busy), .dev_out_data(dev_out_data),
    .dev_out_pulse(dev_out_pulse), .dev_out_ack(dev_out_ack),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [4:0] data; logic stop;} in_exp_t;
  typedef struct packed {logic [1:0] ch; logic [4:0] data;} out_exp_t;

  // reference model
  logic [4:0] mq [NCHAN][$];
  logic [NCHAN-1:0] m_ovf = '0;
  logic m_to = 1'b0;
  bit o_act = 0, o_tmo = 0, o_noise = 0;
  int o_t = 0, o_j = 0, o_B = 0, o_ch = 0;
  in_exp_t exp_in[$];
  out_exp_t exp_out[$];

  // model view of the DUT state for the current cycle
  bit mon_on = 0;
  logic s_valid = 0, s_stop = 0, s_busy = 0, s_to = 0;
  logic [NCHAN-1:0] s_full = '0, s_ovf = '0;

  // next-cycle stimulus
  logic [1:0] n_sel = '0;
  logic n_en = 1'b1, n_req = 1'b0, n_fl = 1'b0, n_ostb = 1'b0;
  logic [NCHAN-1:0] n_stb = '0;
  logic [4:0] n_dat [NCHAN];
  logic [4:0] n_odata = '0;
  int n_j = 1;
  bit n_noise = 0;

  task automatic tick();
    int sz [NCHAN];
    logic [4:0] hd;
    @(negedge CLOCK);
    sel = n_sel;
    enable = n_en;
    flush = n_fl;
    io_in_req = n_fl ? 1'b0 : n_req;
    dev_in_stb = n_stb;
    for (int k = 0; k < NCHAN; k++) dev_in_data[k*DATA_W +: DATA_W] = n_dat[k];
    io_out_stb = n_ostb;
    io_out_data = n_odata;

    for (int k = 0; k < NCHAN; k++) begin
      sz[k] = mq[k].size();
      s_full[k] = (sz[k] == DEPTH);
    end
    s_valid = n_en && (sz[n_sel] != 0);
    s_stop = 1'b0;
    if (s_valid) s_stop = (mq[n_sel][0] == STOP_CODE);
    s_ovf = m_ovf;

    if (o_act) o_t++;
    if (o_act && o_tmo && o_t >= PULSE_CYC + ACK_TIMEOUT) m_to = 1'b1;
    s_to = m_to;
    s_busy = o_act && (o_t < o_B);
    if (o_act && !s_busy) o_act = 0;

    dev_out_ack = NCHAN'($urandom());
    if (o_act)
      dev_out_ack[o_ch] = (o_noise && o_t >= 1 && o_t <= 5) ||
                          (o_t >= PULSE_CYC - 1 + o_j && o_t < o_B);

    if (n_ostb && n_en && !s_busy) begin
      o_act = 1; o_t = -1; o_ch = int'(n_sel); o_j = n_j; o_noise = n_noise;
      o_tmo = (n_j > ACK_TIMEOUT);
      o_B = PULSE_CYC + (o_tmo ? ACK_TIMEOUT : n_j) + GAP_CYC;
      exp_out.push_back(out_exp_t'({n_sel, n_odata}));
    end

    if (!n_fl && n_req && s_valid) begin
      hd = mq[n_sel].pop_front();
      exp_in.push_back(in_exp_t'({hd, hd == STOP_CODE}));
    end
    for (int k = 0; k < NCHAN; k++) begin
      if (n_stb[k]) begin
        if (sz[k] == DEPTH) m_ovf[k] = 1'b1;
        else if (!(n_fl && k == int'(n_sel))) mq[k].push_back(n_dat[k]);
      end
    end
    if (n_fl) mq[n_sel].delete();

    mon_on = 1;
    n_stb = '0; n_fl = 1'b0; n_ostb = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int ch, input logic [4:0] d);
    n_stb[ch] = 1'b1;
    n_dat[ch] = d;
    tick();
  endtask

  task automatic out_req(input logic [1:0] ch, input logic [4:0] d, input int j);
    n_sel = ch; n_odata = d; n_j = j; n_ostb = 1'b1; n_noise = 1;
    tick();
  endtask

  task automatic apply_reset();
    @(posedge CLOCK);
    #3;
    rst_n = 1'b0;
    enable = 1'b1;
    #1;
    chk("rst_pulse", dev_out_pulse, '0);
    chk("rst_busy", io_out_busy, 1'b0);
    chk("rst_full", dev_in_full, '0);
    chk("rst_ovf", err_overflow, '0);
    chk("rst_timeout", err_timeout, 1'b0);
    chk("rst_dout", dev_out_data, '0);
    for (int s = 0; s < NCHAN; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_valid", io_in_valid, 1'b0);
    end
    mon_on = 0;
    for (int k = 0; k < NCHAN; k++) mq[k].delete();
    exp_in.delete(); exp_out.delete();
    m_ovf = '0; m_to = 1'b0; o_act = 0;
    dev_in_stb = '0; flush = 1'b0; io_out_stb = 1'b0; io_in_req = 1'b0; dev_out_ack = '0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    rst_n = 1'b1;
  endtask

  // monitor / scoreboard consumer
  initial begin
    bit in_p;
    int width;
    logic [4:0] last_d;
    logic [NCHAN-1:0] last_p;
    in_exp_t ei;
    out_exp_t eo;
    in_p = 0; width = 0; last_d = '0; last_p = '0;
    forever begin
      @(negedge CLOCK);
      #2;
      if (!mon_on || !rst_n) begin
        in_p = 0; width = 0; last_d = '0; last_p = '0;
      end else begin
        chk("io_in_valid", io_in_valid, s_valid);
        chk("io_in_stop", io_in_stop, s_stop);
        chk("dev_in_full", dev_in_full, s_full);
        chk("err_overflow", err_overflow, s_ovf);
        chk("io_out_busy", io_out_busy, s_busy);
        chk("err_timeout", err_timeout, s_to);
        if (io_in_valid && io_in_req) begin
          chk("pop_expected", exp_in.size() != 0, 1'b1);
          if (exp_in.size() != 0) begin
            ei = exp_in.pop_front();
            chk("io_in_data", io_in_data, ei.data);
            chk("io_in_stop_pop", io_in_stop, ei.stop);
          end
        end
        if (dev_out_pulse != '0) begin
          if (!in_p) begin
            chk("pulse_expected", exp_out.size() != 0, 1'b1);
            if (exp_out.size() != 0) begin
              eo = exp_out.pop_front();
              last_d = eo.data;
              last_p = NCHAN'(1) << eo.ch;
            end
            in_p = 1; width = 0;
          end
          width++;
          chk("dev_out_pulse", dev_out_pulse, last_p);
        end else if (in_p) begin
          chk("pulse_width", width, PULSE_CYC);
          in_p = 0;
        end
        chk("dev_out_data", dev_out_data, last_d);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NCHAN; k++) n_dat[k] = '0;
    enable = 1'b1;
    #12;
    chk("por_busy", io_out_busy, 1'b0);
    chk("por_pulse", dev_out_pulse, '0);
    chk("por_valid", io_in_valid, 1'b0);
    chk("por_ovf", err_overflow, '0);
    @(negedge CLOCK);
    rst_n = 1'b1;

    // in-order delivery with req held
    n_sel = 2'd1; n_en = 1'b1; n_req = 1'b1;
    push(1, 5'h15); push(1, 5'h03); push(1, 5'h1F);
    ticks(3);

    // overflow on ch2, then drain
    n_sel = 2'd2; n_req = 1'b0;
    push(2, 5'h01); push(2, 5'h02); push(2, 5'h04); push(2, 5'h08); push(2, 5'h10);
    ticks(2);
    n_req = 1'b1;
    ticks(6);

    // stop-code flag
    n_sel = 2'd0; n_req = 1'b0;
    push(0, STOP_CODE); push(0, 5'h03);
    ticks(1);
    n_req = 1'b1;
    ticks(3);

    // strobe on ch3 with ack after 20 cycles, extra stb and sel/enable churn while busy
    n_req = 1'b0;
    out_req(2'd3, 5'h0A, 20);
    ticks(10);
    n_sel = 2'd0; n_en = 1'b0;
    ticks(2);
    n_en = 1'b1;
    out_req(2'd1, 5'h11, 3);
    ticks(25);

    // ack on the very last WAIT_ACK cycle, then no ack at all
    out_req(2'd2, 5'h05, ACK_TIMEOUT);
    ticks(PULSE_CYC + ACK_TIMEOUT + GAP_CYC + 4);
    out_req(2'd1, 5'h1B, ACK_TIMEOUT + 500);
    ticks(PULSE_CYC + ACK_TIMEOUT + GAP_CYC + 4);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      n_sel = 2'($urandom());
      n_en = ($urandom() % 8) != 0;
      n_req = 1'($urandom());
      for (int k = 0; k < NCHAN; k++) begin
        n_stb[k] = ($urandom() % 10) < 3;
        n_dat[k] = (($urandom() % 6) == 0) ? STOP_CODE : 5'($urandom());
      end
      n_fl = ($urandom() % 40) == 0;
      n_ostb = ($urandom() % 20) == 0;
      n_odata = 5'($urandom());
      n_j = (($urandom() % 25) == 0) ? ACK_TIMEOUT + 1 + int'($urandom() % 50)
                                     : 1 + int'($urandom() % 30);
      n_noise = 1'($urandom());
      tick();
    end
    n_ostb = 1'b0; n_fl = 1'b0; n_stb = '0;
    ticks(PULSE_CYC + ACK_TIMEOUT + GAP_CYC + 4);

    // reset mid-pulse with half-full FIFOs
    n_en = 1'b1; n_req = 1'b0; n_sel = 2'd0;
    push(0, 5'h07); push(0, 5'h09); push(1, 5'h0C); push(1, 5'h0D);
    out_req(2'd2, 5'h13, 10);
    ticks(3);
    apply_reset();

    // short traffic after reset, then settle and check nothing is left over
    n_sel = 2'd1; n_req = 1'b1;
    push(1, 5'h1E); push(1, STOP_CODE);
    out_req(2'd0, 5'h16, 1);
    ticks(30);
    chk("exp_in_empty", exp_in.size(), 0);
    chk("exp_out_empty", exp_out.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
